dsp_chain_accum: RTL and testbench
==================================

// Module: dsp_chain_accum
// PURPOSE
// - Tail-of-chain accumulator: consumes the 37-bit cascade result from the last int_sop_2
//   in a DSP chain and sums it over a variable-length group of beats (one dot product).
// - At group end: round, arithmetic-shift, truncate/saturate to OUT_W; present on valid/ready.
// - Sits directly downstream of the chain; one instance per chain.
// PARAMETERS
// - IN_W    37  width of chain result (signed two's complement)
// - ACC_W   48  accumulator width; overflow wraps silently
// - SHIFT    8  right-shift applied to final sum (0 = no shift, no rounding)
// - OUT_W   16  signed output width
// - CNT_W    8  beat-counter width
// PORTS
// - clk        in   1      clock, all state on rising edge
// - reset      in   1      asynchronous, active-low (0 = reset)
// - in_valid   in   1      chain_in beat valid
// - in_ready   out  1      beat accepted when in_valid && in_ready
// - chain_in   in   IN_W   signed chain result
// - in_last    in   1      qualifies final beat of group
// - out_valid  out  1      result valid
// - out_ready  in   1      result consumed when out_valid && out_ready
// - out_data   out  OUT_W  signed rounded result
// - out_count  out  CNT_W  beats in group (saturates at 2^CNT_W-1)
// - out_sat    out  1      result was clipped (0 when DSP_ACC_SAT_EN undefined)
// BEHAVIOUR
// - Reset: acc=0, cnt=0, state=EMPTY, out_valid=0, out_data=0, out_count=0, out_sat=0.
//   Reset mid-group discards partial sum and any held output.
// - in_ready = !out_valid || out_ready (combinational); beats with in_valid=0 are ignored.
// - States: EMPTY (acc==0, cnt==0) -> BUSY on accepted non-last beat; BUSY stays on
//   accepted non-last beats; accepted last beat from either -> EMPTY, output loaded.
// - Accepted non-last: acc <= acc + sext(chain_in); cnt <= sat(cnt+1).
// - Accepted last: sum = acc + sext(chain_in); out_data <= rs(sum); out_count <= sat(cnt+1);
//   out_valid <= 1; acc <= 0; cnt <= 0. Latency: result visible cycle after acceptance.
// - rs(x): SHIFT>0 -> (x + 2^(SHIFT-1)) >>> SHIFT (round half toward +inf); then to OUT_W.
// - out_valid && out_ready without new last beat -> out_valid <= 0; out_data holds value.
// - Simultaneous pop and accepted last beat: new result loaded, out_valid stays 1.
// - While out_valid && !out_ready: in_ready=0; acc, cnt, outputs stable.
// CONFIGURATION
// - DSP_ACC_SAT_EN defined: rounded value outside [-2^(OUT_W-1), 2^(OUT_W-1)-1] clamps to
//   nearest bound, out_sat=1 with that result.
// - Undefined: low OUT_W bits taken (wrap); out_sat constant 0.
// STRUCTURE
// - Package dsp_chain_pkg: CHAIN_W=37 constant, state typedef {EMPTY, BUSY}.
// - Sub-module dsp_acc_round_sat: combinational round/shift/saturate (ACC_W->OUT_W),
//   macro-controlled; instantiated once on the final-sum path.
// TESTING (SHIFT=8, OUT_W=16, out_ready=1 unless stated)
// - Single beat 256, in_last=1 -> next cycle out_valid=1, out_data=1, out_count=1.
// - Four beats of 1000, last on 4th -> out_data=16, out_count=4; acc back to 0.
// - Single beat -384, last -> out_data=-1 (0xFFFF).
// - Hold out_ready=0 after result, drive next beats -> in_ready=0, nothing accepted,
//   out_data stable; raise out_ready -> in_ready=1 same cycle, beat accepted.
// - Single beat 0x1000000, last -> SAT_EN: out_data=0x7FFF, out_sat=1; else 0x0000, out_sat=0.
// - 3 beats of 500, pulse reset low, release, beat 512 last -> out_data=2, out_count=1.

Source files
------------

// File: rtl/dsp_chain_pkg.sv
// Shared constants and state encoding for the DSP chain tail accumulator.
package dsp_chain_pkg;

  localparam int unsigned CHAIN_W = 37;

  typedef logic [0:0] state_t;
  localparam state_t EMPTY = 1'b0;
  localparam state_t BUSY  = 1'b1;

endpackage

// File: rtl/dsp_acc_round_sat.sv
// Combinational round-half-up, arithmetic shift and narrowing of a final accumulator sum.
// DSP_ACC_SAT_EN selects clamping with a saturation flag; otherwise the low bits wrap.
module dsp_acc_round_sat #(
  parameter int unsigned ACC_W = 48,
  parameter int unsigned SHIFT = 8,
  parameter int unsigned OUT_W = 16
) (
  input  logic signed [ACC_W-1:0] sum,
  output logic signed [OUT_W-1:0] data,
  output logic                    sat
);

  // One guard bit so the rounding bias can never wrap the sum.
  localparam int unsigned EW = ACC_W + 1;

  logic signed [EW-1:0] ext;
  logic signed [EW-1:0] shifted;

  assign ext = {sum[ACC_W-1], sum};

  if (SHIFT > 0) begin : g_round
    localparam logic signed [EW-1:0] HALF = {{(EW-1){1'b0}}, 1'b1} << (SHIFT - 1);
    assign shifted = (ext + HALF) >>> SHIFT;
  end else begin : g_pass
    assign shifted = ext;
  end

`ifdef DSP_ACC_SAT_EN
  localparam logic signed [EW-1:0] MAX_V = {{(EW-OUT_W+1){1'b0}}, {(OUT_W-1){1'b1}}};
  localparam logic signed [EW-1:0] MIN_V = ~MAX_V;

  always_comb begin
    data = OUT_W'(shifted);
    sat  = 1'b0;
    if (shifted > MAX_V) begin
      data = OUT_W'(MAX_V);
      sat  = 1'b1;
    end else if (shifted < MIN_V) begin
      data = OUT_W'(MIN_V);
      sat  = 1'b1;
    end
  end
`else
  assign data = OUT_W'(shifted);
  assign sat  = 1'b0;
`endif

endmodule

// File: rtl/dsp_chain_accum.sv
// Tail-of-chain accumulator: sums chain results over a group and emits a rounded result.
// Saturating output enabled by defining DSP_ACC_SAT_EN.
module dsp_chain_accum
  import dsp_chain_pkg::*;
#(
  parameter int unsigned IN_W  = CHAIN_W,
  parameter int unsigned ACC_W = 48,
  parameter int unsigned SHIFT = 8,
  parameter int unsigned OUT_W = 16,
  parameter int unsigned CNT_W = 8
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [IN_W-1:0]         chain_in,
  input  logic                    in_last,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic signed [OUT_W-1:0] out_data,
  output logic [CNT_W-1:0]        out_count,
  output logic                    out_sat
);

  state_t                    state_q, state_d;
  logic signed [ACC_W-1:0]   acc_q, acc_d;
  logic [CNT_W-1:0]          cnt_q, cnt_d;
  logic                      out_valid_q, out_valid_d;
  logic signed [OUT_W-1:0]   out_data_q, out_data_d;
  logic [CNT_W-1:0]          out_count_q, out_count_d;
  logic                      out_sat_q, out_sat_d;

  logic                      accept;
  logic signed [ACC_W-1:0]   in_ext;
  logic signed [ACC_W-1:0]   acc_base;
  logic signed [ACC_W-1:0]   sum;
  logic [CNT_W-1:0]          cnt_base;
  logic [CNT_W-1:0]          cnt_inc;
  logic signed [OUT_W-1:0]   rs_data;
  logic                      rs_sat;

  assign in_ready = !out_valid_q || out_ready;
  assign accept   = in_valid && in_ready;
  assign in_ext   = {{(ACC_W-IN_W){chain_in[IN_W-1]}}, chain_in};

  // A fresh group starts from zero regardless of what the registers hold.
  assign acc_base = (state_q == EMPTY) ? '0 : acc_q;
  assign cnt_base = (state_q == EMPTY) ? '0 : cnt_q;
  assign sum      = acc_base + in_ext;
  assign cnt_inc  = (cnt_base == '1) ? cnt_base : cnt_base + CNT_W'(1);

  dsp_acc_round_sat #(
    .ACC_W (ACC_W),
    .SHIFT (SHIFT),
    .OUT_W (OUT_W)
  ) u_round_sat (
    .sum  (sum),
    .data (rs_data),
    .sat  (rs_sat)
  );

  always_comb begin
    state_d     = state_q;
    acc_d       = acc_q;
    cnt_d       = cnt_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_count_d = out_count_q;
    out_sat_d   = out_sat_q;
    if (out_valid_q && out_ready) begin
      out_valid_d = 1'b0;
    end
    if (accept) begin
      if (in_last) begin
        out_valid_d = 1'b1;
        out_data_d  = rs_data;
        out_count_d = cnt_inc;
        out_sat_d   = rs_sat;
        acc_d       = '0;
        cnt_d       = '0;
        state_d     = EMPTY;
      end else begin
        acc_d   = sum;
        cnt_d   = cnt_inc;
        state_d = BUSY;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= EMPTY;
      acc_q       <= '0;
      cnt_q       <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_count_q <= '0;
      out_sat_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      acc_q       <= acc_d;
      cnt_q       <= cnt_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_count_q <= out_count_d;
      out_sat_q   <= out_sat_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_count = out_count_q;
  assign out_sat   = out_sat_q;

endmodule

// File: tb/tb_dsp_chain_accum.sv
// Scoreboard bench for dsp_chain_accum at SHIFT=8, OUT_W=16, CNT_W=8.
module tb_dsp_chain_accum;

  logic               clk = 1'b0;
  logic               reset;
  logic               in_valid;
  logic               in_ready;
  logic [36:0]        chain_in;
  logic               in_last;
  logic               out_valid;
  logic               out_ready;
  logic signed [15:0] out_data;
  logic [7:0]         out_count;
  logic               out_sat;

  typedef struct {
    logic [15:0] data;
    logic [7:0]  count;
    logic        sat;
  } exp_t;

  exp_t   sb[$];
  int     checks   = 0;
  int     failures = 0;
  longint model_acc = 0;
  int     model_cnt = 0;

  always #5 clk = ~clk;

  dsp_chain_accum u_dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .chain_in  (chain_in),
    .in_last   (in_last),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_count (out_count),
    .out_sat   (out_sat)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  function automatic exp_t model_rs(input longint s, input int c);
    exp_t   e;
    longint r;
    r       = (s + 128) >>> 8;
    e.count = 8'(c);
    e.sat   = 1'b0;
`ifdef DSP_ACC_SAT_EN
    if (r > 32767) begin
      e.data = 16'h7fff;
      e.sat  = 1'b1;
    end else if (r < -32768) begin
      e.data = 16'h8000;
      e.sat  = 1'b1;
    end else begin
      e.data = r[15:0];
    end
`else
    e.data = r[15:0];
`endif
    return e;
  endfunction

  task automatic model_accept(input longint v, input logic last);
    model_acc = model_acc + v;
    if (model_cnt < 255) model_cnt++;
    if (last) begin
      sb.push_back(model_rs(model_acc, model_cnt));
      model_acc = 0;
      model_cnt = 0;
    end
  endtask

  // Called at posedge+1; returns at posedge+1 of the accepting edge.
  task automatic beat(input longint v, input logic last);
    bit done = 1'b0;
    in_valid = 1'b1;
    chain_in = v[36:0];
    in_last  = last;
    for (int i = 0; i < 50 && !done; i++) begin
      @(negedge clk);
      if (in_ready) begin
        model_accept(v, last);
        done = 1'b1;
      end
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
    in_last  = 1'b0;
    if (!done) check_eq("accept_timeout", 32'd0, 32'd1);
  endtask

  task automatic drain();
    for (int i = 0; i < 20 && sb.size() != 0; i++) begin
      @(posedge clk);
      #1;
    end
    check_eq("drain", sb.size(), 0);
  endtask

  always @(negedge clk) begin
    if (reset && out_valid && out_ready) begin
      if (sb.size() == 0) begin
        check_eq("unexpected_out", 32'd1, 32'd0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check_eq("out_data", 32'(out_data[15:0]), 32'(e.data));
        check_eq("out_count", 32'(out_count), 32'(e.count));
        check_eq("out_sat", 32'(out_sat), 32'(e.sat));
      end
    end
  end

  initial begin
    reset     = 1'b0;
    in_valid  = 1'b0;
    chain_in  = '0;
    in_last   = 1'b0;
    out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check_eq("rst_out_valid", 32'(out_valid), 32'd0);
    check_eq("rst_out_data", 32'(out_data[15:0]), 32'd0);
    check_eq("rst_out_count", 32'(out_count), 32'd0);
    check_eq("rst_out_sat", 32'(out_sat), 32'd0);
    check_eq("rst_in_ready", 32'(in_ready), 32'd1);
    reset = 1'b1;
    @(posedge clk);
    #1;

    // Single beat, with latency visible right after the accepting edge.
    beat(256, 1'b1);
    check_eq("lat_valid", 32'(out_valid), 32'd1);
    check_eq("lat_data", 32'(out_data[15:0]), 32'd1);
    drain();

    for (int i = 0; i < 4; i++) beat(1000, i == 3);
    drain();
    beat(-384, 1'b1);
    drain();

    // Backpressure: result held, input stalled, then released.
    out_ready = 1'b0;
    beat(512, 1'b1);
    in_valid = 1'b1;
    chain_in = 37'd768;
    in_last  = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      check_eq("hold_in_ready", 32'(in_ready), 32'd0);
      check_eq("hold_valid", 32'(out_valid), 32'd1);
      check_eq("hold_data", 32'(out_data[15:0]), 32'd2);
    end
    out_ready = 1'b1;
    #1;
    check_eq("release_in_ready", 32'(in_ready), 32'd1);
    model_accept(768, 1'b1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_last  = 1'b0;
    drain();

    // Output range boundaries.
    beat(64'sh1000000, 1'b1);
    beat(-64'sh1000000, 1'b1);
    beat(32767 * 256, 1'b1);
    beat(-32768 * 256, 1'b1);
    drain();

    // Beat counter saturation.
    for (int i = 0; i < 300; i++) beat(1, i == 299);
    drain();

    // Back-to-back random groups.
    for (int g = 0; g < 6; g++) begin
      int len;
      len = int'($urandom_range(1, 4));
      for (int i = 0; i < len; i++) begin
        longint v;
        v = longint'($urandom_range(0, 2 ** 21)) - 64'sd1048576;
        beat(v, i == len - 1);
      end
    end
    drain();

    // Reset mid-group discards the partial sum.
    for (int i = 0; i < 3; i++) beat(500, 1'b0);
    reset = 1'b0;
    model_acc = 0;
    model_cnt = 0;
    #1;
    check_eq("midrst_valid", 32'(out_valid), 32'd0);
    @(posedge clk);
    #1;
    reset = 1'b1;
    @(posedge clk);
    #1;
    beat(512, 1'b1);
    check_eq("post_rst_data", 32'(out_data[15:0]), 32'd2);
    check_eq("post_rst_count", 32'(out_count), 32'd1);
    drain();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
